lfu_cache_ctrl: RTL and testbench

Cache controller that drives one `LFUBloqueCache` data/counter array. It accepts 16-bit CPU load/store requests, keeps the tag/valid/dirty store, and performs fully associative hit detection. On a miss it evicts the LFU victim reported by the array, writing the victim back to RAM if it is dirty, then fills the line from RAM. It sits between the CPU port and the line-wide RAM port. It is the initiator for every array access.

---
 rtl/lfu_cache_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_lfu_cache_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfu_cache_ctrl.sv
// rtl/lfu_cache_ctrl.sv - LFU cache controller: tag store, hit detection, victim write-back and line fill
// Ports: clk, gen_reset_n (async, active-low)
//   CPU   : cpu_req/cpu_we/cpu_addr/cpu_wdata in, cpu_ready pulse + cpu_rdata out
//   RAM   : ram_req/ram_we/ram_addr/ram_wdata out, ram_ack/ram_rdata in (line wide)
//   Array : write_enable/write_enable_ram/write_enable_cpu/read_enable/adress/data_in out,
//           data_out/min_adress in
module lfu_cache_ctrl #(
  parameter int bitsDirect  = 4,
  parameter int sizeBitLine = 64,
  parameter int sizeAddr    = 16
) (
  input  logic                    clk,
  input  logic                    gen_reset_n,
  input  logic                    cpu_req,
  input  logic                    cpu_we,
  input  logic [sizeAddr-1:0]     cpu_addr,
  input  logic [15:0]             cpu_wdata,
  output logic                    cpu_ready,
  output logic [15:0]             cpu_rdata,
  output logic                    ram_req,
  output logic                    ram_we,
  output logic [sizeAddr-3:0]     ram_addr,
  output logic [sizeBitLine-1:0]  ram_wdata,
  input  logic                    ram_ack,
  input  logic [sizeBitLine-1:0]  ram_rdata,
  output logic                    write_enable,
  output logic                    write_enable_ram,
  output logic [1:0]              write_enable_cpu,
  output logic                    read_enable,
  output logic [bitsDirect-1:0]   adress,
  output logic [sizeBitLine-1:0]  data_in,
  input  logic [sizeBitLine-1:0]  data_out,
  input  logic [bitsDirect-1:0]   min_adress
);

  localparam int LINES = 1 << bitsDirect;
  localparam int TAGW  = sizeAddr - 2;

  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_RD, S_RD_CAP, S_WR, S_EV_RD, S_EV_CAP,
    S_EV_WR, S_FILL, S_FILL_WR, S_RESP
  } state_t;

  state_t                 state;
  logic                   req_we;
  logic [sizeAddr-1:0]    req_addr;
  logic [15:0]            req_wdata;
  logic [bitsDirect-1:0]  victim;
  logic [TAGW-1:0]        tag_q [LINES];
  logic [LINES-1:0]       valid_q;
  logic [LINES-1:0]       dirty_q;

  logic                   hit;
  logic [bitsDirect-1:0]  hit_idx;
  logic [TAGW-1:0]        req_tag;
  logic [5:0]             word_lsb;

  assign req_tag  = req_addr[sizeAddr-1:2];
  assign word_lsb = {req_addr[1:0], 4'b0000};

  // Fully associative compare; the tag store never holds two valid copies of a tag.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == req_tag)) begin
        hit     = 1'b1;
        hit_idx = bitsDirect'(i);
      end
    end
  end

  // Outputs are registered on entry to the state that owns them, so every strobe
  // is high exactly during its named state and defaults back to 0 otherwise.
  always_ff @(posedge clk or negedge gen_reset_n) begin
    if (!gen_reset_n) begin
      state            <= S_IDLE;
      req_we           <= 1'b0;
      req_addr         <= '0;
      req_wdata        <= '0;
      victim           <= '0;
      valid_q          <= '0;
      dirty_q          <= '0;
      for (int i = 0; i < LINES; i++) tag_q[i] <= '0;
      cpu_ready        <= 1'b0;
      cpu_rdata        <= '0;
      ram_req          <= 1'b0;
      ram_we           <= 1'b0;
      ram_addr         <= '0;
      ram_wdata        <= '0;
      write_enable     <= 1'b0;
      write_enable_ram <= 1'b0;
      write_enable_cpu <= '0;
      read_enable      <= 1'b0;
      adress           <= '0;
      data_in          <= '0;
    end else begin
      cpu_ready        <= 1'b0;
      read_enable      <= 1'b0;
      write_enable     <= 1'b0;
      write_enable_ram <= 1'b0;
      write_enable_cpu <= '0;
      case (state)
        S_IDLE: begin
          if (cpu_req) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_addr;
            req_wdata <= cpu_wdata;
            state     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit) begin
            adress <= hit_idx;
            if (req_we) begin
              write_enable     <= 1'b1;
              write_enable_cpu <= req_addr[1:0];
              data_in          <= {{(sizeBitLine-16){1'b0}}, req_wdata};
              state            <= S_WR;
            end else begin
              read_enable <= 1'b1;
              state       <= S_RD;
            end
          end else begin
            victim <= min_adress;
            if (valid_q[min_adress] && dirty_q[min_adress]) begin
              adress      <= min_adress;
              read_enable <= 1'b1;
              state       <= S_EV_RD;
            end else begin
              ram_req  <= 1'b1;
              ram_we   <= 1'b0;
              ram_addr <= req_tag;
              state    <= S_FILL;
            end
          end
        end
        S_RD:     state <= S_RD_CAP;
        S_RD_CAP: begin
          cpu_rdata <= data_out[word_lsb +: 16];
          cpu_ready <= 1'b1;
          state     <= S_RESP;
        end
        S_WR: begin
          dirty_q[adress] <= 1'b1;
          cpu_ready       <= 1'b1;
          state           <= S_RESP;
        end
        S_EV_RD:  state <= S_EV_CAP;
        S_EV_CAP: begin
          // ram_wdata doubles as the write-back buffer.
          ram_wdata <= data_out;
          ram_req   <= 1'b1;
          ram_we    <= 1'b1;
          ram_addr  <= tag_q[victim];
          state     <= S_EV_WR;
        end
        S_EV_WR: begin
          if (ram_ack) begin
            ram_we   <= 1'b0;
            ram_addr <= req_tag;
            state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (ram_ack) begin
            ram_req          <= 1'b0;
            write_enable     <= 1'b1;
            write_enable_ram <= 1'b1;
            adress           <= victim;
            data_in          <= ram_rdata;
            state            <= S_FILL_WR;
          end
        end
        S_FILL_WR: begin
          tag_q[victim]   <= req_tag;
          valid_q[victim] <= 1'b1;
          dirty_q[victim] <= 1'b0;
          state           <= S_LOOKUP;
        end
        S_RESP:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfu_cache_ctrl.sv
// tb/tb_lfu_cache_ctrl.sv - self-checking bench for lfu_cache_ctrl with array and RAM models
module tb_lfu_cache_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        gen_reset_n;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata;
  logic        cpu_ready;
  logic [15:0] cpu_rdata;
  logic        ram_req, ram_we;
  logic [13:0] ram_addr;
  logic [63:0] ram_wdata;
  logic        ram_ack;
  logic        model_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [63:0] ram_rdata = '0;
  logic        write_enable, write_enable_ram, read_enable;
  logic [1:0]  write_enable_cpu;
  logic [3:0]  adress, min_adress;
  logic [63:0] data_in, data_out;

  assign ram_ack = model_ack | stray_ack;

  lfu_cache_ctrl #(.bitsDirect(4), .sizeBitLine(64), .sizeAddr(16)) dut (
    .clk(clk), .gen_reset_n(gen_reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_ack(ram_ack), .ram_rdata(ram_rdata),
    .write_enable(write_enable), .write_enable_ram(write_enable_ram),
    .write_enable_cpu(write_enable_cpu), .read_enable(read_enable),
    .adress(adress), .data_in(data_in), .data_out(data_out), .min_adress(min_adress)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Line array: registered read, full-line or single-word write.
  logic [63:0] arr [16];
  always @(posedge clk) begin
    if (write_enable) begin
      if (write_enable_ram) arr[adress] <= data_in;
      else arr[adress][int'(write_enable_cpu)*16 +: 16] <= data_in[15:0];
    end
    if (read_enable) data_out <= arr[adress];
  end

  // RAM: each request is logged, acknowledged after ram_delay cycles.
  typedef struct packed {logic we; logic [13:0] addr; logic [63:0] wdata;} txn_t;
  txn_t        txn_q[$];
  txn_t        exp_q[$];
  logic [63:0] ram_mem [logic [13:0]];
  int          ram_delay = 0;
  int          ram_cnt = 0;
  bit          ram_busy = 0;
  txn_t        ram_cur;
  int          req_cycles = 0;

  function automatic logic [63:0] ram_line(input logic [13:0] a);
    if (ram_mem.exists(a)) return ram_mem[a];
    return {2'b10, a, 2'b01, ~a, 2'b11, a ^ 14'h1555, 2'b00, a + 14'd7};
  endfunction

  always @(negedge clk) begin
    model_ack = 1'b0;
    if (ram_req) req_cycles++;
    if (!ram_req) ram_busy = 0;
    else begin
      if (!ram_busy) begin
        ram_busy = 1;
        ram_cnt = ram_delay;
        ram_cur.we = ram_we;
        ram_cur.addr = ram_addr;
        ram_cur.wdata = ram_wdata;
        txn_q.push_back(ram_cur);
      end
      if (ram_cnt == 0) begin
        model_ack = 1'b1;
        ram_busy = 0;
        if (ram_cur.we) ram_mem[ram_cur.addr] = ram_cur.wdata;
        else ram_rdata = ram_line(ram_cur.addr);
      end else ram_cnt--;
    end
  end

  // Reference cache contents: what each index should hold after each request.
  logic        m_valid [16];
  logic        m_dirty [16];
  logic [13:0] m_tag   [16];
  logic [63:0] m_data  [16];

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endtask

  task automatic model_op(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [3:0] vict, input int d,
                          output logic [15:0] rd, output int exp_lat);
    int          idx;
    int          off;
    logic [13:0] tag;
    txn_t        t;
    idx = -1;
    off = int'(addr[1:0]);
    tag = addr[15:2];
    exp_q.delete();
    for (int i = 0; i < 16; i++) if (m_valid[i] && m_tag[i] == tag) idx = i;
    exp_lat = we ? 3 : 4;
    if (idx < 0) begin
      idx = int'(vict);
      if (m_valid[idx] && m_dirty[idx]) begin
        t.we = 1'b1; t.addr = m_tag[idx]; t.wdata = m_data[idx];
        exp_q.push_back(t);
        exp_lat = -1;
      end else exp_lat += d + 3;
      t.we = 1'b0; t.addr = tag; t.wdata = '0;
      exp_q.push_back(t);
      m_data[idx]  = ram_line(tag);
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tag;
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      m_data[idx][16*off +: 16] = wd;
      m_dirty[idx] = 1'b1;
    end
    rd = m_data[idx][16*off +: 16];
  endtask

  function automatic bit txn_ok();
    if (txn_q.size() != exp_q.size()) return 0;
    foreach (exp_q[i]) begin
      if (txn_q[i].we !== exp_q[i].we || txn_q[i].addr !== exp_q[i].addr) return 0;
      if (exp_q[i].we && txn_q[i].wdata !== exp_q[i].wdata) return 0;
    end
    return 1;
  endfunction

  // Issues one request and reports the cycle of the first cpu_ready and the pulse count.
  task automatic do_op(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                       input logic [3:0] vict, input int d,
                       output int lat, output int pulses, output logic [15:0] rd_exp,
                       output int exp_lat);
    min_adress = vict;
    ram_delay  = d;
    txn_q.delete();
    model_op(we, addr, wd, vict, d, rd_exp, exp_lat);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    @(posedge clk);
    lat = 0;
    pulses = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
      end
      if (cpu_ready) begin
        pulses++;
        if (lat == 0) lat = c;
      end
      if (lat != 0 && c >= lat + 2) break;
    end
  endtask

  int          lat, pulses, exp_lat;
  logic [15:0] rd_exp;

  task automatic test_reset();
    gen_reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; min_adress = '0;
    model_clear();
    repeat (3) @(negedge clk);
    n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ready got %b want 0", cpu_ready); end
    n_checks++; if (cpu_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_cpu_rdata got %h want 0", cpu_rdata); end
    n_checks++; if (ram_req !== 1'b0) begin n_fail++; $display("FAIL reset_ram_req got %b want 0", ram_req); end
    n_checks++; if ({write_enable, write_enable_ram, write_enable_cpu, read_enable} !== 5'b0) begin
      n_fail++; $display("FAIL reset_array_strobes got %b want 0", {write_enable, write_enable_ram, write_enable_cpu, read_enable}); end
    n_checks++; if ({adress, ram_addr, ram_we} !== 19'b0) begin
      n_fail++; $display("FAIL reset_addresses got %h want 0", {adress, ram_addr, ram_we}); end
    n_checks++; if ({data_in, ram_wdata} !== 128'b0) begin n_fail++; $display("FAIL reset_data got %h want 0", {data_in, ram_wdata}); end
    gen_reset_n = 1'b1;
  endtask

  task automatic test_first_fill();
    ram_mem[14'h0010] = 64'h4444_3333_2222_1111;
    do_op(1'b0, 16'h0040, 16'h0, 4'd0, 0, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (!txn_ok() || txn_q.size() != 1) begin n_fail++; $display("FAIL first_fill_txn got %0d txns want one fetch of 0010", txn_q.size()); end
    n_checks++; if (cpu_rdata !== 16'h1111) begin n_fail++; $display("FAIL first_fill_rdata got %h want 1111", cpu_rdata); end
    n_checks++; if (lat !== 7) begin n_fail++; $display("FAIL first_fill_latency got %0d want 7", lat); end
    n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL first_fill_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_store_load();
    do_op(1'b1, 16'h0042, 16'hBEEF, 4'd5, 2, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL store_hit_latency got %0d want 3", lat); end
    n_checks++; if (txn_q.size() != 0) begin n_fail++; $display("FAIL store_hit_ram got %0d txns want 0", txn_q.size()); end
    do_op(1'b0, 16'h0042, 16'h0, 4'd5, 2, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL load_hit_latency got %0d want 4", lat); end
    n_checks++; if (cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL load_hit_rdata got %h want beef", cpu_rdata); end
    n_checks++; if (txn_q.size() != 0) begin n_fail++; $display("FAIL load_hit_ram got %0d txns want 0", txn_q.size()); end
    do_op(1'b0, 16'h0043, 16'h0, 4'd5, 2, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (cpu_rdata !== 16'h4444) begin n_fail++; $display("FAIL offset3_rdata got %h want 4444", cpu_rdata); end
  endtask

  task automatic test_dirty_evict();
    int bad = 0;
    for (int i = 1; i < 16; i++) begin
      do_op(1'b0, {14'h100 + 14'(i), 2'b00}, 16'h0, 4'(i), 1, lat, pulses, rd_exp, exp_lat);
      if (!txn_ok() || cpu_rdata !== rd_exp || lat !== exp_lat) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL fill_all_lines got %0d bad fills want 0", bad); end
    do_op(1'b1, {14'h106, 2'b01}, 16'hCAFE, 4'd9, 1, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (lat !== 3 || txn_q.size() != 0) begin n_fail++; $display("FAIL dirty_store got lat %0d txns %0d want 3/0", lat, txn_q.size()); end
    do_op(1'b0, {14'h300, 2'b10}, 16'h0, 4'd6, 3, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (!txn_ok()) begin n_fail++; $display("FAIL evict_txns got %0d txns want writeback+fetch", txn_q.size()); end
    n_checks++; if (txn_q.size() < 1 || txn_q[0].we !== 1'b1 || txn_q[0].wdata[31:16] !== 16'hCAFE) begin
      n_fail++; $display("FAIL evict_wdata got size %0d want we=1 with cafe in word1", txn_q.size()); end
    n_checks++; if (cpu_rdata !== rd_exp || pulses !== 1) begin n_fail++; $display("FAIL evict_rdata got %h/%0d want %h/1", cpu_rdata, pulses, rd_exp); end
    do_op(1'b0, {14'h300, 2'b10}, 16'h0, 4'd6, 3, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (lat !== 4 || txn_q.size() != 0) begin n_fail++; $display("FAIL post_evict_hit got lat %0d txns %0d want 4/0", lat, txn_q.size()); end
  endtask

  task automatic test_clean_victim();
    do_op(1'b0, {14'h301, 2'b00}, 16'h0, 4'd2, 4, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (!txn_ok() || txn_q.size() != 1 || txn_q[0].we !== 1'b0) begin
      n_fail++; $display("FAIL clean_victim_txn got %0d txns want a single fetch", txn_q.size()); end
    n_checks++; if (lat !== 11) begin n_fail++; $display("FAIL clean_miss_latency got %0d want 11", lat); end
    n_checks++; if (cpu_rdata !== rd_exp) begin n_fail++; $display("FAIL clean_victim_rdata got %h want %h", cpu_rdata, rd_exp); end
  endtask

  task automatic test_ack_delay();
    int delays [2] = '{0, 7};
    @(negedge clk); stray_ack = 1'b1;
    @(negedge clk); stray_ack = 1'b0;
    do_op(1'b0, {14'h301, 2'b00}, 16'h0, 4'd3, 0, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (lat !== 4 || txn_q.size() != 0) begin n_fail++; $display("FAIL stray_ack_ignored got lat %0d txns %0d want 4/0", lat, txn_q.size()); end
    foreach (delays[k]) begin
      req_cycles = 0;
      do_op(1'b0, {14'h310 + 14'(k), 2'b11}, 16'h0, 4'(3 + k), delays[k], lat, pulses, rd_exp, exp_lat);
      n_checks++; if (req_cycles !== delays[k] + 1) begin n_fail++; $display("FAIL ack_delay_req_hold got %0d want %0d", req_cycles, delays[k] + 1); end
      n_checks++; if (pulses !== 1 || lat !== delays[k] + 7) begin n_fail++; $display("FAIL ack_delay_done got pulses %0d lat %0d want 1/%0d", pulses, lat, delays[k] + 7); end
      n_checks++; if (cpu_rdata !== rd_exp) begin n_fail++; $display("FAIL ack_delay_rdata got %h want %h", cpu_rdata, rd_exp); end
    end
  endtask

  task automatic test_back_to_back();
    int p1 = 0, p2 = 0;
    min_adress = 4'd0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0042;
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (cpu_ready) begin
        if (p1 == 0) p1 = c;
        else if (p2 == 0) begin p2 = c; cpu_req = 1'b0; end
      end
    end
    cpu_req = 1'b0;
    n_checks++; if (p1 !== 4 || p2 !== 9) begin n_fail++; $display("FAIL back_to_back got pulses at %0d,%0d want 4,9", p1, p2); end
    n_checks++; if (cpu_rdata !== 16'hBEEF) begin n_fail++; $display("FAIL back_to_back_rdata got %h want beef", cpu_rdata); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [15:0] a, wd;
      int          d;
      we = 1'($urandom);
      a  = {14'h200 + 14'($urandom_range(11, 0)), 2'($urandom_range(3, 0))};
      wd = 16'($urandom);
      d  = $urandom_range(3, 0);
      do_op(we, a, wd, 4'($urandom_range(15, 0)), d, lat, pulses, rd_exp, exp_lat);
      n_checks++; if (!txn_ok()) begin n_fail++; $display("FAIL random_txn op %0d got %0d txns want %0d", n, txn_q.size(), exp_q.size()); end
      n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL random_pulses op %0d got %0d want 1", n, pulses); end
      if (!we) begin
        n_checks++; if (cpu_rdata !== rd_exp) begin n_fail++; $display("FAIL random_rdata op %0d got %h want %h", n, cpu_rdata, rd_exp); end
      end
      if (exp_lat > 0) begin
        n_checks++; if (lat !== exp_lat) begin n_fail++; $display("FAIL random_latency op %0d got %0d want %0d", n, lat, exp_lat); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit          seen = 0;
    logic [13:0] t7;
    t7 = m_tag[7];
    do_op(1'b1, {t7, 2'b00}, 16'h5A5A, 4'd0, 0, lat, pulses, rd_exp, exp_lat);
    min_adress = 4'd7;
    ram_delay = 20;
    txn_q.delete();
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = {14'h3FF, 2'b00};
    @(posedge clk);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      cpu_req = 1'b0;
      if (ram_req && ram_we) seen = 1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL reset_mid_reach_ev_wr got 0 want 1"); end
    #2 gen_reset_n = 1'b0;
    #1;
    n_checks++; if (ram_req !== 1'b0 || cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid_abort got ram_req %b cpu_ready %b want 0/0", ram_req, cpu_ready); end
    @(negedge clk);
    gen_reset_n = 1'b1;
    model_clear();
    do_op(1'b0, {t7, 2'b00}, 16'h0, 4'd7, 0, lat, pulses, rd_exp, exp_lat);
    n_checks++; if (!txn_ok() || txn_q.size() != 1) begin n_fail++; $display("FAIL reset_mid_next_miss got %0d txns want one fetch", txn_q.size()); end
    n_checks++; if (lat !== 7 || cpu_rdata !== rd_exp) begin n_fail++; $display("FAIL reset_mid_reload got lat %0d data %h want 7/%h", lat, cpu_rdata, rd_exp); end
  endtask

  initial begin
    test_reset();
    test_first_fill();
    test_store_load();
    test_dirty_evict();
    test_clean_victim();
    test_ack_delay();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
